char_wr_ctrl: RTL and testbench

Sequences the character stream from the UART byte FIFO into the on-screen character buffer that feeds the character extractor and ASCII ROM path. It pops bytes one at a time, interprets a small set of control codes, keeps the text cursor, and generates all write cycles into the character RAM, including line and screen clears. It is the single writer of that RAM; the display side only reads it.

---
 rtl/char_wr_ctrl.sv | 155 +++++++++++++++
 tb/tb_char_wr_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/char_wr_ctrl.sv
// Character RAM write sequencer: pops UART bytes, handles control codes,
// keeps the text cursor and performs line/screen clears.
module char_wr_ctrl #(
  parameter int COLS   = 50,
  parameter int ROWS   = 18,
  parameter int ADDR_W = 10
) (
  input  logic              clk_ctrl,
  input  logic              Rst_p,
  input  logic              fifo_empty,
  input  logic [7:0]        fifo_data,
  output logic              rd_en,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [7:0]        buf_wdata,
  output logic [5:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);

  localparam logic [2:0] S_CLR_ALL = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_POP     = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_CLR_ROW = 3'd4;

  localparam logic [ADDR_W:0]   L_NCELL  = (ADDR_W+1)'(COLS*ROWS);
  localparam logic [ADDR_W:0]   L_NCOLS  = (ADDR_W+1)'(COLS);
  localparam logic [ADDR_W-1:0] L_COLS_A = ADDR_W'(COLS);
  localparam logic [7:0]        SPACE    = 8'h20;

  logic [2:0]        r_state;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W-1:0] r_base;   // running row*COLS for the cursor row
  logic [7:0]        r_byte;
  logic [5:0]        r_col;
  logic [4:0]        r_row;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [7:0]        r_wdata;
  logic              r_busy;

  logic              w_print_in, w_bs_in, w_print;
  logic              w_last_col, w_last_row;
  logic [4:0]        w_nrow;
  logic [ADDR_W-1:0] w_nbase, w_cur_addr;

  assign w_print_in = (fifo_data >= 8'h20) && (fifo_data <= 8'h7E);
  assign w_bs_in    = (fifo_data == 8'h08) && (r_col != 6'd0);
  assign w_print    = (r_byte >= 8'h20) && (r_byte <= 8'h7E);
  assign w_last_col = (r_col == 6'(COLS-1));
  assign w_last_row = (r_row == 5'(ROWS-1));
  assign w_nrow     = w_last_row ? 5'd0 : r_row + 5'd1;
  assign w_nbase    = w_last_row ? '0 : r_base + L_COLS_A;
  assign w_cur_addr = r_base + ADDR_W'(r_col);

  assign rd_en      = (r_state == S_IDLE) && !fifo_empty && !Rst_p;
  assign buf_we     = r_we;
  assign buf_waddr  = r_waddr;
  assign buf_wdata  = r_wdata;
  assign cursor_col = r_col;
  assign cursor_row = r_row;
  assign busy       = r_busy;

  always_ff @(posedge clk_ctrl) begin
    if (Rst_p) begin
      r_state <= S_CLR_ALL;
      r_cnt   <= '0;
      r_base  <= '0;
      r_byte  <= 8'h00;
      r_col   <= 6'd0;
      r_row   <= 5'd0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= SPACE;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_CLR_ALL: begin
          if (r_cnt == L_NCELL) begin
            r_we    <= 1'b0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_we    <= 1'b1;
            r_waddr <= r_cnt[ADDR_W-1:0];
            r_wdata <= SPACE;
            r_cnt   <= r_cnt + 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_IDLE: begin
          r_we <= 1'b0;
          if (!fifo_empty) begin
            r_state <= S_POP;
            r_busy  <= 1'b1;
          end
        end
        S_POP: begin
          // decode straight off the FIFO bus so the write lands in EXEC
          r_byte  <= fifo_data;
          r_we    <= w_print_in || w_bs_in;
          r_wdata <= w_print_in ? fifo_data : SPACE;
          r_waddr <= w_print_in ? w_cur_addr : w_cur_addr - ADDR_W'(1);
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_we    <= 1'b0;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if ((w_print && w_last_col) || r_byte == 8'h0A) begin
            if (w_print) r_col <= 6'd0;
            r_row   <= w_nrow;
            r_base  <= w_nbase;
            r_we    <= 1'b1;
            r_waddr <= w_nbase;
            r_wdata <= SPACE;
            r_cnt   <= (ADDR_W+1)'(1);
            r_state <= S_CLR_ROW;
            r_busy  <= 1'b1;
          end else if (w_print) begin
            r_col <= r_col + 6'd1;
          end else if (r_byte == 8'h0D) begin
            r_col <= 6'd0;
          end else if (r_byte == 8'h08) begin
            if (r_col != 6'd0) r_col <= r_col - 6'd1;
          end else if (r_byte == 8'h0C) begin
            r_col   <= 6'd0;
            r_row   <= 5'd0;
            r_base  <= '0;
            r_cnt   <= '0;
            r_state <= S_CLR_ALL;
            r_busy  <= 1'b1;
          end
        end
        S_CLR_ROW: begin
          if (r_cnt == L_NCOLS) begin
            r_we    <= 1'b0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_waddr <= r_base + r_cnt[ADDR_W-1:0];
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_CLR_ALL;
          r_cnt   <= '0;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_wr_ctrl.sv
// Bench for char_wr_ctrl: queue FIFO model, write log and a cursor/text model.
module tb_char_wr_ctrl;
  localparam int COLS = 50, ROWS = 18, AW = 10, NCELL = COLS * ROWS;

  logic          clk_ctrl = 1'b0, Rst_p = 1'b1, fifo_empty = 1'b1;
  logic [7:0]    fifo_data = 8'h00;
  logic          rd_en, buf_we, busy;
  logic [AW-1:0] buf_waddr;
  logic [7:0]    buf_wdata;
  logic [5:0]    cursor_col;
  logic [4:0]    cursor_row;

  char_wr_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(AW)) dut (
    .clk_ctrl(clk_ctrl), .Rst_p(Rst_p), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .rd_en(rd_en), .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy));

  always #5 clk_ctrl = ~clk_ctrl;

  int total = 0, bad = 0, cyc = 0, viol = 0, busy_cnt = 0;
  int obs[$], wcyc[$], rcyc[$], exq[$];
  logic [7:0] fq[$];
  logic rd_flag = 1'b0;
  int m_col = 0, m_row = 0;

  // write/pop log, sampled mid-cycle
  always @(negedge clk_ctrl) begin
    cyc++;
    rd_flag = rd_en;
    if (rd_en) begin
      rcyc.push_back(cyc);
      if (fifo_empty || busy) viol++;
    end
    if (buf_we) begin
      obs.push_back(int'(buf_waddr) * 256 + int'(buf_wdata));
      wcyc.push_back(cyc);
    end
    if (busy) busy_cnt++;
  end

  // non-show-ahead FIFO: data appears the cycle after the pop
  always @(posedge clk_ctrl) begin
    #1;
    if (rd_flag && fq.size() > 0) fifo_data = fq.pop_front();
    fifo_empty = (fq.size() == 0);
  end

  task automatic chk(input string tag, input int o, input int e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk_ctrl);
    #2;
  endtask

  task automatic m_clr_row();
    for (int c = 0; c < COLS; c++) exq.push_back((m_row * COLS + c) * 256 + 32);
  endtask

  task automatic m_clr_all();
    for (int a = 0; a < NCELL; a++) exq.push_back(a * 256 + 32);
  endtask

  task automatic mdl(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      exq.push_back((m_row * COLS + m_col) * 256 + int'(b));
      if (m_col < COLS - 1) m_col++;
      else begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        m_clr_row();
      end
    end else if (b == 8'h0D) m_col = 0;
    else if (b == 8'h0A) begin
      m_row = (m_row + 1) % ROWS;
      m_clr_row();
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        exq.push_back((m_row * COLS + m_col) * 256 + 32);
      end
    end else if (b == 8'h0C) begin
      m_col = 0;
      m_row = 0;
      m_clr_all();
    end
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    mdl(b);
  endtask

  task automatic drain(input string tag);
    int stable = 0, n = 0;
    while (stable < 3 && n < 5000) begin
      tick();
      n++;
      if (fq.size() == 0 && busy === 1'b0 && rd_en === 1'b0) stable++;
      else stable = 0;
    end
    chk({tag, "_settle"}, int'(stable >= 3), 1);
  endtask

  task automatic compare(input string tag);
    int m;
    chk({tag, "_nwr"}, obs.size(), exq.size());
    if (obs.size() > 0 && obs.size() == exq.size()) begin
      m = obs.size() - 1;
      for (int i = obs.size() - 1; i >= 0; i--) if (obs[i] != exq[i]) m = i;
      chk({tag, "_wr"}, obs[m], exq[m]);
    end
    chk({tag, "_col"}, int'(cursor_col), m_col);
    chk({tag, "_row"}, int'(cursor_row), m_row);
    obs.delete(); wcyc.delete(); rcyc.delete(); exq.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd"}, int'(rd_en), 0);
    chk({tag, "_we"}, int'(buf_we), 0);
    chk({tag, "_addr"}, int'(buf_waddr), 0);
    chk({tag, "_data"}, int'(buf_wdata), 32);
    chk({tag, "_col"}, int'(cursor_col), 0);
    chk({tag, "_row"}, int'(cursor_row), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int nlf, found;
    logic [7:0] b;
    repeat (3) tick();
    chk_reset_vals("rst");
    obs.delete(); wcyc.delete(); rcyc.delete();
    m_clr_all();
    busy_cnt = 0;
    Rst_p = 1'b0;
    drain("clr_all");
    chk("clr_all_busy", busy_cnt, NCELL);
    if (wcyc.size() == NCELL) chk("clr_all_span", wcyc[NCELL-1] - wcyc[0], NCELL - 1);
    chk("clr_all_nrd", rcyc.size(), 0);
    compare("clr_all");

    // "AB": write at pop+2, next pop at pop+3
    push(8'h41); push(8'h42);
    drain("ab");
    chk("ab_npop", rcyc.size(), 2);
    if (rcyc.size() == 2 && wcyc.size() == 2) begin
      chk("ab_lat0", wcyc[0] - rcyc[0], 2);
      chk("ab_lat1", wcyc[1] - rcyc[1], 2);
      chk("ab_rate", rcyc[1] - rcyc[0], 3);
    end
    chk("ab_col2", int'(cursor_col), 2);
    compare("ab");

    // 51 printables from 0/0: wrap + row clear
    push(8'h0D);
    for (int i = 0; i < 51; i++) push(8'($urandom_range(32, 126)));
    drain("wrap");
    if (rcyc.size() == 52) chk("wrap_gap", rcyc[51] - rcyc[50], 3 + COLS);
    chk("wrap_col1", int'(cursor_col), 1);
    chk("wrap_row1", int'(cursor_row), 1);
    compare("wrap");

    // reach row 17 col 5, then LF wraps to row 0 and clears it
    push(8'h0D);
    nlf = (ROWS - 1 - m_row + ROWS) % ROWS;
    for (int i = 0; i < nlf; i++) push(8'h0A);
    for (int i = 0; i < 5; i++) push(8'($urandom_range(32, 126)));
    drain("to_r17");
    chk("r17_row", int'(cursor_row), 17);
    chk("r17_col", int'(cursor_col), 5);
    compare("to_r17");
    push(8'h0A);
    drain("lf_wrap");
    if (obs.size() == COLS) begin
      chk("lf_first", obs[0], 32);
      chk("lf_last", obs[COLS-1], (COLS - 1) * 256 + 32);
    end
    chk("lf_row0", int'(cursor_row), 0);
    compare("lf_wrap");
    push(8'h0D);
    drain("cr");
    compare("cr");

    // backspace at col 0, at col 3, then an ignored control byte
    push(8'h08);
    drain("bs0");
    compare("bs0");
    for (int i = 0; i < 3; i++) push(8'($urandom_range(32, 126)));
    push(8'h08);
    drain("bs3");
    if (obs.size() == 4) chk("bs3_space", obs[3], 2 * 256 + 32);
    chk("bs3_col2", int'(cursor_col), 2);
    compare("bs3");
    push(8'h07);
    drain("bel");
    compare("bel");

    // random byte mix with random gaps in the FIFO supply
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: b = 8'($urandom_range(32, 126));
        3: b = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
        4: b = 8'h08;
        default: b = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(127, 255));
      endcase
      push(b);
      repeat ($urandom_range(0, 4)) tick();
    end
    drain("rand");
    compare("rand");

    // FF, then reset mid-clear at address 300
    push(8'h0C);
    found = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      tick();
      if (buf_we === 1'b1 && buf_waddr === AW'(300)) found = 1;
    end
    chk("ff_reach300", found, 1);
    Rst_p = 1'b1;
    tick();
    Rst_p = 1'b0;
    chk_reset_vals("midrst");
    obs.delete(); wcyc.delete(); rcyc.delete(); exq.delete();
    m_col = 0; m_row = 0;
    m_clr_all();
    busy_cnt = 0;
    drain("ff_rst");
    chk("ff_rst_busy", busy_cnt, NCELL);
    compare("ff_rst");

    chk("rd_rules", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
